// File: rtl/pc_pkg.sv
// Shared constants and command decode for the program-counter sequencer.
// The enum order documents command priority, highest first after hold.
package pc_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_STEP      = 1;
    localparam int DEF_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_STALL,
        CMD_ENABLE,
        CMD_CALL,
        CMD_RET,
        CMD_BRANCH,
        CMD_INCR
    } cmd_e;

    // Exactly one command wins per cycle; everything below it is ignored.
    function automatic cmd_e decode_cmd(input logic stall, input logic enable,
                                        input logic call, input logic ret,
                                        input logic branch, input logic increment);
        if (stall)          return CMD_STALL;
        else if (enable)    return CMD_ENABLE;
        else if (call)      return CMD_CALL;
        else if (ret)       return CMD_RET;
        else if (branch)    return CMD_BRANCH;
        else if (increment) return CMD_INCR;
        else                return CMD_HOLD;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Command and status bundle of the PC sequencer. Commands are level inputs
// sampled on every rising clk edge; there is no valid/ready handshake.
interface pc_sequencer_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             enable;
    logic             call;
    logic             ret;
    logic             branch;
    logic             increment;
    logic             err_clr;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] Q;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output stall, enable, call, ret, branch, increment, err_clr, D, offset,
        input  Q, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, enable, call, ret, branch, increment, err_clr, D, offset,
        output Q, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address LIFO. A push while full overwrites the oldest entry,
// which sits exactly at the write pointer once the ring has filled.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[wr_ptr - AW'(1)];

    // Pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - AW'(1);
            count  <= count - CW'(1);
        end
    end

    // Entry contents are don't-care after reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised load/call/return/branch/increment and a
// return-address stack with sticky overflow/underflow flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               STEP      = DEF_STEP,
    parameter int               RAS_DEPTH = DEF_RAS_DEPTH,
    localparam int              CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 clr,
    pc_sequencer_if.slave        bus,
    output cmd_e                 cmd_dbg
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    cmd_e             cmd;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_q;
    logic             unf_q;

    assign cmd     = decode_cmd(bus.stall, bus.enable, bus.call, bus.ret,
                                bus.branch, bus.increment);
    assign cmd_dbg = cmd;

    always_comb begin
        pc_next = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (cmd)
            CMD_ENABLE: pc_next = bus.D;
            CMD_CALL: begin
                pc_next = bus.D;
                push    = 1'b1;
                ovf_set = ras_full;
            end
            CMD_RET: begin
                if (ras_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pc_next = ras_top;
                    pop     = 1'b1;
                end
            end
            CMD_BRANCH: pc_next = pc_q + bus.offset;
            CMD_INCR:   pc_next = pc_q + STEP_W;
            default:    pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            pc_q <= INIT;
        else
            pc_q <= pc_next;
    end

    // err_clr acts even under stall; a same-cycle new error still lands.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !bus.err_clr) || ovf_set;
            unf_q <= (unf_q && !bus.err_clr) || unf_set;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (pc_q + STEP_W),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    assign bus.Q         = pc_q;
    assign bus.ras_count = ras_count;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// commands compared against a queue-based reference model.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int          WIDTH     = 32;
    localparam logic [31:0] INIT      = 32'h100;
    localparam int          RAS_DEPTH = 4;

    logic clk;
    logic clr;
    cmd_e cmd_dbg;

    pc_sequencer_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .INIT      (INIT),
        .STEP      (1),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus),
        .cmd_dbg (cmd_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = INIT;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] ra;
        if (clr) begin
            model_reset();
            return;
        end
        if (bus.err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (bus.stall) begin
        end else if (bus.enable) begin
            m_pc = bus.D;
        end else if (bus.call) begin
            ra = m_pc + 32'd1;
            m_stack.push_back(ra);
            if (m_stack.size() > RAS_DEPTH) begin
                m_stack.delete(0);
                m_ovf = 1'b1;
            end
            m_pc = bus.D;
        end else if (bus.ret) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else m_pc = m_stack.pop_back();
        end else if (bus.branch) begin
            m_pc = m_pc + bus.offset;
        end else if (bus.increment) begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_stack.size();
        check($sformatf("%s.q", tag), bus.Q, m_pc);
        check($sformatf("%s.count", tag), 32'(bus.ras_count), 32'(sz));
        check($sformatf("%s.empty", tag), 32'(bus.ras_empty), 32'(sz == 0));
        check($sformatf("%s.full", tag), 32'(bus.ras_full), 32'(sz == RAS_DEPTH));
        check($sformatf("%s.ovf", tag), 32'(bus.ras_ovf), 32'(m_ovf));
        check($sformatf("%s.unf", tag), 32'(bus.ras_unf), 32'(m_unf));
    endtask

    // driver tasks
    task automatic idle();
        bus.stall = 0; bus.enable = 0; bus.call = 0; bus.ret = 0;
        bus.branch = 0; bus.increment = 0; bus.err_clr = 0;
        bus.D = '0; bus.offset = '0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_enable(input logic [31:0] d, input string tag);
        idle(); bus.enable = 1; bus.D = d; step(tag);
    endtask

    task automatic do_call(input logic [31:0] d, input string tag);
        idle(); bus.call = 1; bus.D = d; step(tag);
    endtask

    task automatic do_ret(input string tag);
        idle(); bus.ret = 1; step(tag);
    endtask

    initial begin
        idle();
        clr = 1'b1;
        model_reset();
        #2;
        check_all("reset_async");
        check("reset.q", bus.Q, 32'h100);
        #10;
        clr = 1'b0;

        // increments after reset
        idle(); bus.increment = 1;
        step("inc1"); check("inc1.const", bus.Q, 32'h101);
        step("inc2"); check("inc2.const", bus.Q, 32'h102);
        step("inc3"); check("inc3.const", bus.Q, 32'h103);

        // negative branch and wrap
        do_enable(32'h10, "ld10");
        idle(); bus.branch = 1; bus.offset = 32'hFFFF_FFF8;
        step("br_neg"); check("br_neg.const", bus.Q, 32'h08);
        do_enable(32'hFFFF_FFFF, "ldmax");
        idle(); bus.increment = 1;
        step("wrap"); check("wrap.const", bus.Q, 32'h0);

        // single call / ret
        do_enable(32'h20, "ld20");
        do_call(32'h80, "call1");
        check("call1.const", bus.Q, 32'h80);
        check("call1.cnt", 32'(bus.ras_count), 32'd1);
        do_ret("ret1");
        check("ret1.const", bus.Q, 32'h21);
        check("ret1.empty", 32'(bus.ras_empty), 32'd1);

        // overflow then drain into underflow
        do_enable(32'h0, "ld0");
        for (int i = 1; i <= 5; i++) do_call(32'(i * 16), $sformatf("ovf_call%0d", i));
        check("ovf.flag", 32'(bus.ras_ovf), 32'd1);
        check("ovf.cnt", 32'(bus.ras_count), 32'd4);
        do_ret("drain1"); check("drain1.const", bus.Q, 32'h41);
        do_ret("drain2"); check("drain2.const", bus.Q, 32'h31);
        do_ret("drain3"); check("drain3.const", bus.Q, 32'h21);
        do_ret("drain4"); check("drain4.const", bus.Q, 32'h11);
        do_ret("unf");
        check("unf.q", bus.Q, 32'h11);
        check("unf.flag", 32'(bus.ras_unf), 32'd1);

        // err_clr while stalled still clears flags
        idle(); bus.stall = 1; bus.err_clr = 1;
        step("stall_errclr");
        check("stall_errclr.ovf", 32'(bus.ras_ovf), 32'd0);
        check("stall_errclr.unf", 32'(bus.ras_unf), 32'd0);
        // new error beats err_clr in the same cycle
        idle(); bus.ret = 1; bus.err_clr = 1;
        step("errclr_race");
        check("errclr_race.unf", 32'(bus.ras_unf), 32'd1);
        idle(); bus.err_clr = 1;
        step("errclr");
        check("errclr.unf", 32'(bus.ras_unf), 32'd0);

        // priority: enable masks call and increment; stall masks enable
        do_call(32'h200, "pre_pri");
        idle(); bus.enable = 1; bus.call = 1; bus.increment = 1; bus.D = 32'h55;
        step("pri_en");
        check("pri_en.const", bus.Q, 32'h55);
        check("pri_en.cnt", 32'(bus.ras_count), 32'd1);
        idle(); bus.stall = 1; bus.enable = 1; bus.D = 32'h99;
        step("pri_stall");
        check("pri_stall.const", bus.Q, 32'h55);

        // asynchronous clear in the middle of a call sequence
        do_call(32'h300, "seq_call1");
        do_call(32'h400, "seq_call2");
        idle(); bus.call = 1; bus.D = 32'h500;
        clr = 1'b1;
        #1;
        model_reset();
        check_all("clr_mid");
        check("clr_mid.q", bus.Q, 32'h100);
        check("clr_mid.cnt", 32'(bus.ras_count), 32'd0);
        step("clr_hold");
        #2;
        clr = 1'b0;
        idle(); bus.increment = 1;
        step("post_clr");
        check("post_clr.const", bus.Q, 32'h101);

        // random commands against the model
        for (int i = 0; i < 400; i++) begin
            bus.stall     = ($urandom_range(0, 7) == 0);
            bus.enable    = ($urandom_range(0, 5) == 0);
            bus.call      = ($urandom_range(0, 2) == 0);
            bus.ret       = ($urandom_range(0, 2) == 0);
            bus.branch    = ($urandom_range(0, 3) == 0);
            bus.increment = ($urandom_range(0, 1) == 0);
            bus.err_clr   = ($urandom_range(0, 9) == 0);
            bus.D         = $urandom;
            bus.offset    = $urandom;
            step($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set PC, D and offset width in bits (min 8).
REQ-002 Parameter INIT, default 0, SHALL set the PC value loaded by reset.
REQ-003 Parameter STEP, default 1, SHALL set the increment amount and the call return-address offset.
REQ-004 Parameter RAS_DEPTH, default 4, SHALL set the return-address stack entry count (power of two, 2..16).
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 clr  in  1  reset, asynchronous and active-high.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 enable  in  1  absolute load: PC <= D.
REQ-009 call  in  1  push PC+STEP, then PC <= D.
REQ-010 ret  in  1  pop top of stack into PC.
REQ-011 branch  in  1  relative jump: PC <= PC + offset.
REQ-012 increment  in  1  PC <= PC + STEP.
REQ-013 D  in  WIDTH  absolute target for enable/call.
REQ-014 offset  in  WIDTH  two's-complement branch displacement.
REQ-015 err_clr  in  1  synchronous clear of sticky error flags.
REQ-016 Q  out  WIDTH  current PC, driven directly from the register.
REQ-017 ras_count  out  clog2(RAS_DEPTH)+1  valid stack entries.
REQ-018 ras_empty, ras_full  out  1 each  ras_count==0 / ras_count==RAS_DEPTH, combinational from count.
REQ-019 ras_ovf, ras_unf  out  1 each  sticky overflow / underflow flags.

Function
REQ-020 Per-cycle command priority SHALL be: stall > enable > call > ret > branch > increment > hold; lower-priority inputs asserted in the same cycle SHALL be ignored entirely, including stack effects.
REQ-021 All PC arithmetic SHALL be modulo 2^WIDTH; carries discarded, no flag raised on wrap.
REQ-022 Every command SHALL take effect at the next rising edge; Q reflects it with one-cycle latency and no combinational path from any input to Q.
REQ-023 call SHALL write PC+STEP (pre-update PC) to the stack top and increment ras_count in the same edge as Q <= D.
REQ-024 call with ras_full SHALL overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH, and set ras_ovf.
REQ-025 ret with ras_count>0 SHALL load Q from the top entry and decrement ras_count.
REQ-026 ret with ras_empty SHALL leave Q and the stack unchanged and set ras_unf.
REQ-027 ras_ovf and ras_unf SHALL remain set until clr or err_clr; a new error in the same cycle as err_clr SHALL win (flag ends set).
REQ-028 stall SHALL freeze Q, stack, count and flags; err_clr during stall SHALL still act.
REQ-029 enable, branch, increment SHALL not modify the stack.

Reset
REQ-030 clr asserted SHALL immediately, independent of clk, force Q=INIT, ras_count=0, ras_ovf=0, ras_unf=0.
REQ-031 clr SHALL override every other input, including mid-stall and same-edge commands; stack entry contents need not be cleared.
REQ-032 First edge after clr deasserts SHALL execute the command then present.

Structure
REQ-033 Shared package pc_pkg SHALL hold default WIDTH, STEP, RAS_DEPTH constants and the command-priority enumeration.
REQ-034 The stack SHALL be a sub-module ras_stack (circular LIFO with push, pop, count, full/empty); PC register and priority decode stay in pc_sequencer.

Verification
REQ-035 clr pulse with INIT=32'h100, then 3 increment cycles -> Q = 0x100, 0x101, 0x102, 0x103.
REQ-036 Q=0x10, branch with offset=32'hFFFFFFF8 -> Q=0x08; Q=32'hFFFFFFFF, increment -> Q=0 (wrap).
REQ-037 Q=0x20, call D=0x80 -> Q=0x80, ras_count=1; then ret -> Q=0x21, ras_empty=1.
REQ-038 RAS_DEPTH=4, five calls from Q=0,0x10,0x20,0x30,0x40 -> ras_ovf=1, count=4; four rets return 0x41,0x31,0x21,0x11; fifth ret -> Q unchanged, ras_unf=1.
REQ-039 Same cycle enable(D=0x55)+call+increment -> Q=0x55, stack unchanged; stall+enable -> Q unchanged.
REQ-040 Assert clr between clock edges during a call sequence -> Q=INIT and count=0 before the next edge; err_clr clears sticky flags next edge.
